// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the stream_mux_rr block.
// Optional feature macro: STREAM_MUX_LAST_LOCK_EN (packet lock on last_i).
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Wrap-around increment of a channel index within 0..n-1.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers, the mux, and one consumer.
// Optional feature macro: STREAM_MUX_LAST_LOCK_EN adds last_i / last_o.
interface stream_mux_rr_if #(
  parameter int NUM_CH    = 4,
  parameter int BIT_WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                 mode_i;
  logic [SEL_W-1:0]     sel_i;
  logic [NUM_CH-1:0]    valid_i;
  logic [BIT_WIDTH-1:0] data_i [NUM_CH];
  logic [NUM_CH-1:0]    ready_o;
  logic                 valid_o;
  logic [BIT_WIDTH-1:0] data_o;
  logic [SEL_W-1:0]     ch_o;
  logic                 ready_i;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic [NUM_CH-1:0]    last_i;
  logic                 last_o;
`endif

  // Mux side: consumes producer beats, drives the registered output.
  modport slave (
    input  mode_i, sel_i, valid_i, data_i, ready_i,
`ifdef STREAM_MUX_LAST_LOCK_EN
    input  last_i,
    output last_o,
`endif
    output ready_o, valid_o, data_o, ch_o
  );

  // Environment side: producers plus consumer.
  modport master (
    output mode_i, sel_i, valid_i, data_i, ready_i,
`ifdef STREAM_MUX_LAST_LOCK_EN
    output last_i,
    input  last_o,
`endif
    input  ready_o, valid_o, data_o, ch_o
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  // Scan channels starting at ptr, wrapping once; take the first request.
  always_comb begin
    int c;
    logic [SEL_W-1:0] c_idx;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    c_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      c_idx = SEL_W'(c);
      if (!any && req[c_idx]) begin
        any        = 1'b1;
        gnt[c_idx] = 1'b1;
        idx        = c_idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin choice
// and a single registered output stage.
// Optional feature macro: STREAM_MUX_LAST_LOCK_EN (hold grant until last_i).
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BIT_WIDTH = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  stream_mux_rr_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                 valid_reg;
  logic [BIT_WIDTH-1:0] data_reg;
  logic [SEL_W-1:0]     ch_reg;
  logic [SEL_W-1:0]     ptr_reg;

  logic [NUM_CH-1:0]    gnt_rr, gnt_fix, gnt;
  logic [SEL_W-1:0]     idx_rr, g_idx;
  logic                 any_rr, g_any;
  logic                 load, xfer, adv;
  logic                 mode_rr;
  logic [NUM_CH-1:0]    ready_vec;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic                 lock_reg;
  logic [SEL_W-1:0]     lock_ch_reg;
  logic                 last_reg;
`endif

  assign mode_rr = (mode_e'(bus.mode_i) == MODE_RR);
  // Full-throughput one-entry stage: refill whenever empty or draining.
  assign load    = !valid_reg || bus.ready_i;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req (bus.valid_i),
    .ptr (ptr_reg),
    .gnt (gnt_rr),
    .idx (idx_rr),
    .any (any_rr)
  );

  // Fixed-select grant; an out-of-range select grants nobody.
  always_comb begin
    gnt_fix = '0;
    if (int'(bus.sel_i) < NUM_CH) gnt_fix[bus.sel_i] = bus.valid_i[bus.sel_i];
  end

  // Final grant: mode choice, overridden by an active packet lock.
  always_comb begin
    if (mode_rr) begin
      gnt   = gnt_rr;
      g_idx = idx_rr;
      g_any = any_rr;
    end else begin
      gnt   = gnt_fix;
      g_idx = bus.sel_i;
      g_any = |gnt_fix;
    end
`ifdef STREAM_MUX_LAST_LOCK_EN
    if (lock_reg) begin
      gnt              = '0;
      gnt[lock_ch_reg] = bus.valid_i[lock_ch_reg];
      g_idx            = lock_ch_reg;
      g_any            = bus.valid_i[lock_ch_reg];
    end
`endif
  end

  assign xfer = g_any && load;
`ifdef STREAM_MUX_LAST_LOCK_EN
  // Pointer stays parked on the locked channel until its last beat.
  assign adv  = xfer && mode_rr && bus.last_i[g_idx];
`else
  assign adv  = xfer && mode_rr;
`endif

  // Per-channel accept; forced low while reset is asserted.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
    assign ready_vec[gi] = gnt[gi] && load && rst_ni;
  end
  assign bus.ready_o = ready_vec;

  // Output stage and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ch_reg    <= '0;
      ptr_reg   <= '0;
    end else begin
      if (xfer) begin
        valid_reg <= 1'b1;
        data_reg  <= bus.data_i[g_idx];
        ch_reg    <= g_idx;
      end else if (load) begin
        valid_reg <= 1'b0;
      end
      if (adv) ptr_reg <= SEL_W'(next_idx(int'(g_idx), NUM_CH));
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  // Packet lock state and registered last flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_reg    <= 1'b0;
      lock_ch_reg <= '0;
      last_reg    <= 1'b0;
    end else if (xfer) begin
      lock_reg    <= !bus.last_i[g_idx];
      lock_ch_reg <= g_idx;
      last_reg    <= bus.last_i[g_idx];
    end
  end
  assign bus.last_o = last_reg;
`endif

  assign bus.valid_o = valid_reg;
  assign bus.data_o  = data_reg;
  assign bus.ch_o    = ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven bench for stream_mux_rr (4-channel and 6-channel builds).
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.NUM_CH(4), .BIT_WIDTH(8)) bus4 ();
  stream_mux_rr_if #(.NUM_CH(6), .BIT_WIDTH(8)) bus6 ();

  stream_mux_rr #(.NUM_CH(4), .BIT_WIDTH(8)) dut4 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus4)
  );

  stream_mux_rr #(.NUM_CH(6), .BIT_WIDTH(8)) dut6 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus6)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [1:0] exp_ch;
  } vec_t;

  localparam int NVEC = 28;
  vec_t tbl [NVEC];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic chk_out4(input string nm, input logic v, input logic [7:0] d, input logic [1:0] ch);
    chk({nm, " valid_o"}, 32'(bus4.valid_o), 32'(v));
    chk({nm, " data_o"},  32'(bus4.data_o),  32'(d));
    chk({nm, " ch_o"},    32'(bus4.ch_o),    32'(ch));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Rows 0-7: round-robin fairness, all channels valid.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1, 8'(8'h10 + (i % 4)), 2'(i % 4)};
    end
    // Sparse round robin, then wrap back to ch0.
    tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[12] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    // Fixed select ch2; pointer must stay at 1.
    tbl[13] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[14] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[15] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // No request: valid_o falls, data/ch hold.
    tbl[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    // Backpressure for three cycles, then drain and refill together.
    tbl[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[19] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tbl[20] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tbl[21] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tbl[22] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    // Empty stage loads even with ready_i low, then holds.
    tbl[23] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
    tbl[24] = '{1'b1, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[25] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    // Fixed select on an idle channel: no grant.
    tbl[26] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
    tbl[27] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

    bus4.mode_i  = 1'b1;
    bus4.sel_i   = '0;
    bus4.valid_i = 4'b1111;
    bus4.ready_i = 1'b1;
    for (int c = 0; c < 4; c++) bus4.data_i[c] = 8'(8'h10 + c);
    bus6.mode_i  = 1'b0;
    bus6.sel_i   = '0;
    bus6.valid_i = '0;
    bus6.ready_i = 1'b1;
    for (int c = 0; c < 6; c++) bus6.data_i[c] = 8'(8'h20 + c);
`ifdef STREAM_MUX_LAST_LOCK_EN
    bus4.last_i = '1;
    bus6.last_i = '1;
`endif

    // Reset held with all channels valid.
    repeat (2) @(posedge clk);
    #1;
    chk_out4("reset", 1'b0, 8'h00, 2'd0);
    chk("reset ready_o", 32'(bus4.ready_o), 32'h0);
    chk("reset6 valid_o", 32'(bus6.valid_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      bus4.mode_i  = tbl[i].mode;
      bus4.sel_i   = tbl[i].sel;
      bus4.valid_i = tbl[i].valid;
      bus4.ready_i = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d ready_o", i), 32'(bus4.ready_o), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk_out4($sformatf("row%0d", i), tbl[i].exp_v, tbl[i].exp_d, tbl[i].exp_ch);
    end

    // Asynchronous reset mid-operation discards the beat and clears the pointer.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out4("midreset", 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.mode_i  = 1'b1;
    bus4.valid_i = 4'b1111;
    bus4.ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk_out4("post-reset", 1'b1, 8'h10, 2'd0);

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Packet lock on ch1 (pointer now 1): three beats, last on the third.
    @(negedge clk);
    bus4.valid_i = 4'b0111;
    bus4.last_i  = 4'b1101;
    #1;
    chk("lock b1 ready_o", 32'(bus4.ready_o), 32'b0010);
    @(posedge clk);
    #1;
    chk_out4("lock b1", 1'b1, 8'h11, 2'd1);
    chk("lock b1 last_o", 32'(bus4.last_o), 32'h0);
    @(negedge clk);
    bus4.mode_i = 1'b0;
    bus4.sel_i  = 2'd0;
    #1;
    chk("lock b2 ready_o", 32'(bus4.ready_o), 32'b0010);
    @(posedge clk);
    #1;
    chk_out4("lock b2", 1'b1, 8'h11, 2'd1);
    chk("lock b2 last_o", 32'(bus4.last_o), 32'h0);
    @(negedge clk);
    bus4.mode_i = 1'b1;
    bus4.last_i = 4'b1111;
    @(posedge clk);
    #1;
    chk_out4("lock b3", 1'b1, 8'h11, 2'd1);
    chk("lock b3 last_o", 32'(bus4.last_o), 32'h1);
    @(posedge clk);
    #1;
    chk_out4("lock after", 1'b1, 8'h12, 2'd2);
    chk("lock after last_o", 32'(bus4.last_o), 32'h1);
`endif

    // Six-channel build: select 5 valid, select 6 out of range, select 4.
    @(negedge clk);
    bus6.mode_i  = 1'b0;
    bus6.sel_i   = 3'd5;
    bus6.valid_i = 6'b100000;
    #1;
    chk("ch6 sel5 ready_o", 32'(bus6.ready_o), 32'b100000);
    @(posedge clk);
    #1;
    chk("ch6 sel5 valid_o", 32'(bus6.valid_o), 32'h1);
    chk("ch6 sel5 data_o",  32'(bus6.data_o),  32'h25);
    chk("ch6 sel5 ch_o",    32'(bus6.ch_o),    32'h5);
    @(negedge clk);
    bus6.sel_i   = 3'd6;
    bus6.valid_i = 6'b111111;
    #1;
    chk("ch6 sel6 ready_o", 32'(bus6.ready_o), 32'h0);
    @(posedge clk);
    #1;
    chk("ch6 sel6 valid_o", 32'(bus6.valid_o), 32'h0);
    chk("ch6 sel6 data_o",  32'(bus6.data_o),  32'h25);
    chk("ch6 sel6 ch_o",    32'(bus6.ch_o),    32'h5);
    @(negedge clk);
    bus6.sel_i = 3'd4;
    #1;
    chk("ch6 sel4 ready_o", 32'(bus6.ready_o), 32'b010000);
    @(posedge clk);
    #1;
    chk("ch6 sel4 data_o", 32'(bus6.data_o), 32'h24);
    chk("ch6 sel4 ch_o",   32'(bus6.ch_o),   32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
